// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the pipeline hazard/forwarding unit: forwarding mux selects,
// mul/div scoreboard states and the hard-wired zero register.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } md_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side bundle of the hazard unit: register tags and stage controls in,
// mux selects, stall/flush and mul/div scoreboard status out.
interface hazard_forward_unit_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] rsD;
  logic [REG_W-1:0] rtD;
  logic [REG_W-1:0] rsE;
  logic [REG_W-1:0] rtE;
  logic [REG_W-1:0] writeRegisterE;
  logic [REG_W-1:0] writeRegisterM;
  logic [REG_W-1:0] writeRegisterW;
  logic             regWriteE;
  logic             regWriteM;
  logic             regWriteW;
  logic             memToRegE;
  logic             memToRegM;
  logic             branchD;
  logic             mdOpD;
  logic             mdStartE;
  logic [REG_W-1:0] mdDestE;

  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             ForwardAD;
  logic             ForwardBD;
  logic             stallF;
  logic             stallD;
  logic             flushE;
  logic             mdBusy;
  logic             mdWriteback;
  logic [REG_W-1:0] mdDest;
  logic             mdOverrun;

  modport master (
    output rsD, rtD, rsE, rtE, writeRegisterE, writeRegisterM, writeRegisterW,
           regWriteE, regWriteM, regWriteW, memToRegE, memToRegM, branchD,
           mdOpD, mdStartE, mdDestE,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD, stallF, stallD, flushE,
           mdBusy, mdWriteback, mdDest, mdOverrun
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeRegisterE, writeRegisterM, writeRegisterW,
           regWriteE, regWriteM, regWriteW, memToRegE, memToRegM, branchD,
           mdOpD, mdStartE, mdDestE,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD, stallF, stallD, flushE,
           mdBusy, mdWriteback, mdDest, mdOverrun
  );

endinterface

// File: rtl/hazard_forward_unit_md_scoreboard.sv
// Scoreboard for the single long-latency mul/div unit: tracks the in-flight
// destination, times the writeback with a down-counter and raises D-stage stalls.
//
//  state | meaning
//  IDLE  | no mul/div in flight
//  BUSY  | op in flight, counter running toward writeback
//  WB    | result written this cycle; a new op may issue back-to-back
module md_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_start,
  input  logic [REG_W-1:0] md_dest_in,
  input  logic             md_op_d,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  output logic             md_busy,
  output logic             md_wb,
  output logic [REG_W-1:0] md_dest,
  output logic             md_overrun,
  output logic             md_stall
);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_W-1:0] dest_q, dest_d;
  logic             busy_q, busy_d;
  logic             wb_q, wb_d;
  logic             ovr_q, ovr_d;
  logic             dest_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MD_LAT - 2);
          dest_d  = md_dest_in;
        end
      end
      BUSY: begin
        // a second issue while busy is dropped but remembered
        if (md_start) ovr_d = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = WB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WB: begin
        if (md_start) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MD_LAT - 2);
          dest_d  = md_dest_in;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
    wb_d   = (state_d == WB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
      busy_q  <= 1'b0;
      wb_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      busy_q  <= busy_d;
      wb_q    <= wb_d;
      ovr_q   <= ovr_d;
    end
  end

  // readers of the pending result wait through WB; a second mul/div only waits in BUSY
  assign dest_hit = ((rs_d != REG_W'(REG_ZERO)) && (rs_d == dest_q)) ||
                    ((rt_d != REG_W'(REG_ZERO)) && (rt_d == dest_q));

  assign md_stall   = ((state_q == BUSY) && md_op_d) || (busy_q && dest_hit);
  assign md_busy    = busy_q;
  assign md_wb      = wb_q;
  assign md_dest    = dest_q;
  assign md_overrun = ovr_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding unit for the 5-stage pipeline: E-stage operand and D-stage
// comparator forwarding, load-use/branch/mul-div stalls.
module hazard_forward_unit
  import pipe_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_forward_unit_if.slave  bus
);

  fwd_sel_t fwd_ae, fwd_be;
  logic     lw_stall, br_stall, md_stall, stall;

  function automatic logic reg_hit(input logic [REG_W-1:0] wr, input logic [REG_W-1:0] src);
    return (src != REG_W'(REG_ZERO)) && (wr == src);
  endfunction

  // M result is the newer value, so it wins over W
  always_comb begin
    fwd_ae = FWD_REG;
    if (bus.regWriteM && reg_hit(bus.writeRegisterM, bus.rsE))      fwd_ae = FWD_M;
    else if (bus.regWriteW && reg_hit(bus.writeRegisterW, bus.rsE)) fwd_ae = FWD_W;

    fwd_be = FWD_REG;
    if (bus.regWriteM && reg_hit(bus.writeRegisterM, bus.rtE))      fwd_be = FWD_M;
    else if (bus.regWriteW && reg_hit(bus.writeRegisterW, bus.rtE)) fwd_be = FWD_W;
  end

  always_comb begin
    lw_stall = bus.memToRegE && bus.regWriteE &&
               (reg_hit(bus.writeRegisterE, bus.rsD) || reg_hit(bus.writeRegisterE, bus.rtD));
    br_stall = bus.branchD &&
               ((bus.regWriteE &&
                 (reg_hit(bus.writeRegisterE, bus.rsD) || reg_hit(bus.writeRegisterE, bus.rtD))) ||
                (bus.memToRegM &&
                 (reg_hit(bus.writeRegisterM, bus.rsD) || reg_hit(bus.writeRegisterM, bus.rtD))));
    stall    = lw_stall || br_stall || md_stall;
  end

  md_scoreboard #(
    .REG_W  (REG_W),
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_md_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .md_start   (bus.mdStartE),
    .md_dest_in (bus.mdDestE),
    .md_op_d    (bus.mdOpD),
    .rs_d       (bus.rsD),
    .rt_d       (bus.rtD),
    .md_busy    (bus.mdBusy),
    .md_wb      (bus.mdWriteback),
    .md_dest    (bus.mdDest),
    .md_overrun (bus.mdOverrun),
    .md_stall   (md_stall)
  );

  assign bus.ForwardAE = fwd_ae;
  assign bus.ForwardBE = fwd_be;
  assign bus.ForwardAD = bus.regWriteM && reg_hit(bus.writeRegisterM, bus.rsD);
  assign bus.ForwardBD = bus.regWriteM && reg_hit(bus.writeRegisterM, bus.rtD);
  assign bus.stallF    = stall;
  assign bus.stallD    = stall;
  assign bus.flushE    = stall;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: vector table, hand-written mul/div
// sequences and a randomized run against a cycle-count reference model.
module tb_hazard_forward_unit;

  localparam int REG_W  = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_W(REG_W)) hif();

  hazard_forward_unit #(
    .REG_W  (REG_W),
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    hif.rsD = '0; hif.rtD = '0; hif.rsE = '0; hif.rtE = '0;
    hif.writeRegisterE = '0; hif.writeRegisterM = '0; hif.writeRegisterW = '0;
    hif.regWriteE = 0; hif.regWriteM = 0; hif.regWriteW = 0;
    hif.memToRegE = 0; hif.memToRegM = 0; hif.branchD = 0;
    hif.mdOpD = 0; hif.mdStartE = 0; hif.mdDestE = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // called just after a rising edge; finished well before the falling edge
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk({name, ".stallF"}, hif.stallF, exp);
    chk({name, ".stallD"}, hif.stallD, exp);
    chk({name, ".flushE"}, hif.flushE, exp);
  endtask

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic       rwE, rwM, rwW, m2rE, m2rM, brD;
    logic [1:0] eAE, eBE;
    logic       eAD, eBD, eSt;
  } vec_t;

  vec_t vecs[11];

  // reference model: cycles remaining until the mul/div writeback cycle
  int         remain;
  logic [4:0] mdest_m;
  logic       ovr_m;

  function automatic logic [1:0] ref_fwd(input logic rwM, input logic [4:0] wrM,
                                         input logic rwW, input logic [4:0] wrW,
                                         input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (rwM && wrM == src) return 2'b10;
    if (rwW && wrW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic names(input logic [4:0] wr, input logic [4:0] a, input logic [4:0] b);
    return (a != 0 && a == wr) || (b != 0 && b == wr);
  endfunction

  initial begin
    rst = 1'b1;
    clear_inputs();
    remain = 0; mdest_m = '0; ovr_m = 1'b0;

    //          rsD rtD rsE rtE wrE wrM wrW rwE rwM rwW m2E m2M brD eAE eBE eAD eBD eSt
    vecs[0]  = '{0,  0,  3,  0,  0,  3,  3,  0,  1,  1,  0,  0,  0,  2,  0,  0,  0,  0};
    vecs[1]  = '{0,  0,  3,  0,  0,  3,  3,  0,  0,  1,  0,  0,  0,  1,  0,  0,  0,  0};
    vecs[2]  = '{0,  0,  0,  0,  0,  0,  0,  1,  1,  1,  0,  0,  0,  0,  0,  0,  0,  0};
    vecs[3]  = '{0,  5,  0,  0,  5,  0,  0,  1,  0,  0,  1,  0,  0,  0,  0,  0,  0,  1};
    vecs[4]  = '{7,  0,  0,  0,  0,  7,  0,  0,  1,  0,  0,  0,  1,  0,  0,  1,  0,  0};
    vecs[5]  = '{7,  0,  0,  0,  0,  7,  0,  0,  1,  0,  0,  1,  1,  0,  0,  1,  0,  1};
    vecs[6]  = '{0,  0,  0,  4,  0,  0,  4,  0,  0,  1,  0,  0,  0,  0,  1,  0,  0,  0};
    vecs[7]  = '{0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  1,  0,  0,  0,  0,  0,  0,  0};
    vecs[8]  = '{6,  1,  0,  0,  6,  0,  0,  1,  0,  0,  0,  0,  1,  0,  0,  0,  0,  1};
    vecs[9]  = '{0,  2,  2,  2,  0,  2,  2,  0,  1,  1,  0,  0,  0,  2,  2,  0,  1,  0};
    vecs[10] = '{0,  0,  8,  8,  0,  8,  8,  0,  0,  0,  0,  1,  0,  0,  0,  0,  0,  0};

    // reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst.mdBusy", hif.mdBusy, 1'b0);
    chk("rst.mdWriteback", hif.mdWriteback, 1'b0);
    chk("rst.mdOverrun", hif.mdOverrun, 1'b0);
    chk("rst.mdDest", hif.mdDest, 5'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // vector table, mul/div idle
    for (int i = 0; i < 11; i++) begin
      clear_inputs();
      hif.rsD = vecs[i].rsD; hif.rtD = vecs[i].rtD;
      hif.rsE = vecs[i].rsE; hif.rtE = vecs[i].rtE;
      hif.writeRegisterE = vecs[i].wrE; hif.writeRegisterM = vecs[i].wrM;
      hif.writeRegisterW = vecs[i].wrW;
      hif.regWriteE = vecs[i].rwE; hif.regWriteM = vecs[i].rwM; hif.regWriteW = vecs[i].rwW;
      hif.memToRegE = vecs[i].m2rE; hif.memToRegM = vecs[i].m2rM; hif.branchD = vecs[i].brD;
      @(negedge clk);
      chk($sformatf("vec%0d.ForwardAE", i), hif.ForwardAE, vecs[i].eAE);
      chk($sformatf("vec%0d.ForwardBE", i), hif.ForwardBE, vecs[i].eBE);
      chk($sformatf("vec%0d.ForwardAD", i), hif.ForwardAD, vecs[i].eAD);
      chk($sformatf("vec%0d.ForwardBD", i), hif.ForwardBD, vecs[i].eBD);
      chk_stall($sformatf("vec%0d", i), vecs[i].eSt);
      step();
    end

    // load-use: stall while the load is in E, forward from M the next cycle
    clear_inputs();
    hif.memToRegE = 1; hif.regWriteE = 1; hif.writeRegisterE = 5; hif.rtD = 5;
    @(negedge clk);
    chk_stall("lw.e", 1'b1);
    step();
    clear_inputs();
    hif.memToRegM = 1; hif.regWriteM = 1; hif.writeRegisterM = 5; hif.rtE = 5;
    @(negedge clk);
    chk("lw.m.ForwardBE", hif.ForwardBE, 2'b10);
    chk_stall("lw.m", 1'b0);
    step();

    // basic mul/div: busy cycles 1..3, writeback cycle 3, reader of rd=9 stalls 1..3
    clear_inputs();
    do_reset();
    hif.rsD = 9; hif.mdStartE = 1; hif.mdDestE = 9;
    @(negedge clk);
    chk_stall("md.c0", 1'b0);
    step();
    hif.mdStartE = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("md.c%0d.mdBusy", k), hif.mdBusy, k <= 3);
      chk($sformatf("md.c%0d.mdWriteback", k), hif.mdWriteback, k == 3);
      chk($sformatf("md.c%0d.mdDest", k), hif.mdDest, 5'd9);
      chk_stall($sformatf("md.c%0d", k), k <= 3);
      step();
    end

    // second mul/div in D waits only while BUSY
    clear_inputs();
    do_reset();
    hif.mdStartE = 1; hif.mdDestE = 12;
    step();
    hif.mdStartE = 0; hif.mdOpD = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk_stall($sformatf("mdop.c%0d", k), k <= 2);
      step();
    end

    // back-to-back issue in WB reloads with no IDLE cycle
    clear_inputs();
    do_reset();
    hif.mdStartE = 1; hif.mdDestE = 10;
    step();
    hif.mdStartE = 0;
    step(); step();
    hif.mdStartE = 1; hif.mdDestE = 11;
    @(negedge clk);
    chk("b2b.wb.mdWriteback", hif.mdWriteback, 1'b1);
    chk("b2b.wb.mdDest", hif.mdDest, 5'd10);
    step();
    hif.mdStartE = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("b2b.c%0d.mdBusy", k), hif.mdBusy, k <= 3);
      chk($sformatf("b2b.c%0d.mdWriteback", k), hif.mdWriteback, k == 3);
      chk($sformatf("b2b.c%0d.mdDest", k), hif.mdDest, 5'd11);
      chk($sformatf("b2b.c%0d.mdOverrun", k), hif.mdOverrun, 1'b0);
      step();
    end

    // issue while BUSY: ignored, overrun sticky
    clear_inputs();
    do_reset();
    hif.mdStartE = 1; hif.mdDestE = 13;
    step();
    hif.mdDestE = 14;
    step();
    hif.mdStartE = 0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("ovr.c%0d.mdOverrun", k), hif.mdOverrun, 1'b1);
      chk($sformatf("ovr.c%0d.mdDest", k), hif.mdDest, 5'd13);
      chk($sformatf("ovr.c%0d.mdWriteback", k), hif.mdWriteback, k == 3);
      step();
    end

    // asynchronous reset mid-BUSY drops the op
    clear_inputs();
    do_reset();
    hif.rsD = 9; hif.mdStartE = 1; hif.mdDestE = 9;
    step();
    step();
    hif.mdStartE = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.mdBusy", hif.mdBusy, 1'b0);
    chk("arst.mdWriteback", hif.mdWriteback, 1'b0);
    chk("arst.mdOverrun", hif.mdOverrun, 1'b0);
    chk("arst.mdDest", hif.mdDest, 5'd0);
    chk_stall("arst", 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("arst.after%0d.mdWriteback", k), hif.mdWriteback, 1'b0);
      chk($sformatf("arst.after%0d.mdBusy", k), hif.mdBusy, 1'b0);
      step();
    end

    // randomized run against the reference model
    clear_inputs();
    do_reset();
    remain = 0; mdest_m = '0; ovr_m = 1'b0;
    for (int c = 0; c < 300; c++) begin
      logic [1:0] e_ae, e_be;
      logic       e_ad, e_bd, e_lw, e_br, e_md;
      hif.rsD = 5'($urandom_range(0, 3)); hif.rtD = 5'($urandom_range(0, 3));
      hif.rsE = 5'($urandom_range(0, 3)); hif.rtE = 5'($urandom_range(0, 3));
      hif.writeRegisterE = 5'($urandom_range(0, 3));
      hif.writeRegisterM = 5'($urandom_range(0, 3));
      hif.writeRegisterW = 5'($urandom_range(0, 3));
      hif.regWriteE = 1'($urandom); hif.regWriteM = 1'($urandom); hif.regWriteW = 1'($urandom);
      hif.memToRegE = 1'($urandom); hif.memToRegM = 1'($urandom); hif.branchD = 1'($urandom);
      hif.mdOpD = ($urandom_range(0, 3) == 0);
      hif.mdStartE = ($urandom_range(0, 4) == 0);
      hif.mdDestE = 5'($urandom_range(0, 3));
      if (c % 100 == 99) begin
        do_reset();
        remain = 0; mdest_m = '0; ovr_m = 1'b0;
      end
      @(negedge clk);
      e_ae = ref_fwd(hif.regWriteM, hif.writeRegisterM, hif.regWriteW, hif.writeRegisterW, hif.rsE);
      e_be = ref_fwd(hif.regWriteM, hif.writeRegisterM, hif.regWriteW, hif.writeRegisterW, hif.rtE);
      e_ad = hif.regWriteM && hif.rsD != 0 && hif.writeRegisterM == hif.rsD;
      e_bd = hif.regWriteM && hif.rtD != 0 && hif.writeRegisterM == hif.rtD;
      e_lw = hif.memToRegE && hif.regWriteE && names(hif.writeRegisterE, hif.rsD, hif.rtD);
      e_br = hif.branchD && ((hif.regWriteE && names(hif.writeRegisterE, hif.rsD, hif.rtD)) ||
                             (hif.memToRegM && names(hif.writeRegisterM, hif.rsD, hif.rtD)));
      e_md = (remain > 1 && hif.mdOpD) || (remain > 0 && names(mdest_m, hif.rsD, hif.rtD));
      chk($sformatf("rnd%0d.ForwardAE", c), hif.ForwardAE, e_ae);
      chk($sformatf("rnd%0d.ForwardBE", c), hif.ForwardBE, e_be);
      chk($sformatf("rnd%0d.ForwardAD", c), hif.ForwardAD, e_ad);
      chk($sformatf("rnd%0d.ForwardBD", c), hif.ForwardBD, e_bd);
      chk_stall($sformatf("rnd%0d", c), e_lw || e_br || e_md);
      chk($sformatf("rnd%0d.mdBusy", c), hif.mdBusy, remain > 0);
      chk($sformatf("rnd%0d.mdWriteback", c), hif.mdWriteback, remain == 1);
      chk($sformatf("rnd%0d.mdDest", c), hif.mdDest, mdest_m);
      chk($sformatf("rnd%0d.mdOverrun", c), hif.mdOverrun, ovr_m);
      @(posedge clk);
      if (hif.mdStartE) begin
        if (remain <= 1) begin
          remain  = MD_LAT - 1;
          mdest_m = hif.mdDestE;
        end else begin
          ovr_m  = 1'b1;
          remain = remain - 1;
        end
      end else if (remain > 0) begin
        remain = remain - 1;
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
